// File: rtl/vm_input_pkg.sv
// Package: vm_input_pkg
// Shared types and constants for the vending-machine input conditioner.
//   state_t      per-channel debounce states
//   CH_*         channel index map: coin (m), accept (a), Moore reset (btnC),
//                Mealy reset (btnD)
package vm_input_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int CH_COIN      = 0;
  localparam int CH_ACCEPT    = 1;
  localparam int CH_RST_MOORE = 2;
  localparam int CH_RST_MEALY = 3;

endpackage

// File: rtl/vm_debounce_ch.sv
// Module: vm_debounce_ch
// One conditioned channel: a 2-flop synchronizer feeding a four-state debounce
// FSM with a stability counter.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   ena    in   0 freezes FSM/counter/level and suppresses pulses
//   raw    in   raw asynchronous input, active-high
//   level  out  debounced level (registered)
//   pulse  out  one-cycle pulse on each accepted press (registered)
module vm_debounce_ch
  import vm_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          pulse_reg;
  logic          s;

  assign s     = sync_reg[1];
  assign level = level_reg;
  assign pulse = pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      state_reg <= STABLE_LO;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      // The synchronizer keeps sampling even while the FSM is frozen.
      sync_reg  <= {sync_reg[0], raw};
      pulse_reg <= 1'b0;
      if (ena) begin
        case (state_reg)
          STABLE_LO: begin
            if (s) begin
              state_reg <= WAIT_HI;
              cnt_reg   <= '0;
            end
          end
          WAIT_HI: begin
            if (!s) begin
              state_reg <= STABLE_LO;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_reg <= STABLE_HI;
              cnt_reg   <= '0;
              level_reg <= 1'b1;
              pulse_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          STABLE_HI: begin
            if (!s) begin
              state_reg <= WAIT_LO;
              cnt_reg   <= '0;
            end
          end
          WAIT_LO: begin
            if (s) begin
              state_reg <= STABLE_HI;
              cnt_reg   <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              // Release: level drops, no pulse.
              state_reg <= STABLE_LO;
              cnt_reg   <= '0;
              level_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          default: begin
            state_reg <= STABLE_LO;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/vm_input_conditioner.sv
// Module: vm_input_conditioner
// Front-end for the vending-machine FSM: debounces N_IN raw inputs and emits
// clean levels plus single-cycle press pulses (channel map in vm_input_pkg).
// Optional feature macro: VM_COIN_LOCKOUT_EN -- when defined, a passed coin
// pulse starts a LOCKOUT_CYCLES hold-off during which further coin pulses are
// dropped; btn_level is never affected.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   tile enable; 0 freezes debounce state, no pulses
//   btn_raw    in   [N_IN] raw asynchronous inputs, active-high
//   btn_level  out  [N_IN] debounced levels
//   btn_pulse  out  [N_IN] one-cycle pulses on accepted presses
module vm_input_conditioner
  import vm_input_pkg::*;
#(
  parameter int N_IN            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_IN-1:0] btn_raw,
  output logic [N_IN-1:0] btn_level,
  output logic [N_IN-1:0] btn_pulse
);

  logic [N_IN-1:0] ch_pulse;

  generate
    if (DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
      $error("vm_input_conditioner: DEBOUNCE_CYCLES and LOCKOUT_CYCLES must be >= 1");
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
      vm_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .raw  (btn_raw[gi]),
        .level(btn_level[gi]),
        .pulse(ch_pulse[gi])
      );
    end
  endgenerate

`ifdef VM_COIN_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [LW-1:0] lock_reg;
  logic          coin_ok;

  assign coin_ok = (lock_reg == '0);

  // Only a pulse that actually reaches the output restarts the hold-off;
  // dropped pulses are discarded and do not extend it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg <= '0;
    end else if (ch_pulse[CH_COIN] && coin_ok) begin
      lock_reg <= LW'(LOCKOUT_CYCLES);
    end else if (ena && !coin_ok) begin
      lock_reg <= lock_reg - LW'(1);
    end
  end

  always_comb begin
    btn_pulse          = ch_pulse;
    btn_pulse[CH_COIN] = ch_pulse[CH_COIN] & coin_ok;
  end
`else
  assign btn_pulse = ch_pulse;
`endif

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Testbench for vm_input_conditioner (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8).
// Table-driven vectors, directed corner sequences and a randomized run
// checked against a run-length reference model. Honours VM_COIN_LOCKOUT_EN.
module tb_vm_input_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int LK = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  int n_checks = 0;
  int n_errors = 0;

  vm_input_conditioner #(
    .N_IN(N), .DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(LK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A channel's level follows the synchronized input once that input has
  // differed from the level for D+1 consecutive enabled edges.
  bit [N-1:0] m_s1, m_s2, m_level, m_chp;
  int         m_run [N];
  int         m_lock;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_chp = '0; m_lock = 0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] chp_new;
    chp_new = '0;
    for (int c = 0; c < N; c++) begin
      if (ena) begin
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_level[c] = m_s2[c];
            chp_new[c] = m_s2[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
`ifdef VM_COIN_LOCKOUT_EN
    if (m_chp[0] && m_lock == 0) m_lock = LK;
    else if (ena && m_lock != 0) m_lock--;
`endif
    m_chp = chp_new;
    m_s2  = m_s1;
    m_s1  = btn_raw;
  endtask

  function automatic bit [N-1:0] model_pulse();
    bit [N-1:0] p;
    p = m_chp;
`ifdef VM_COIN_LOCKOUT_EN
    if (m_lock != 0) p[0] = 1'b0;
`endif
    return p;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: inputs already driven; outputs sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_level", btn_level, '0);
    chk("reset_pulse", btn_pulse, '0);
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         ena;
    bit [N-1:0] raw;
    bit [N-1:0] lvl;
    bit [N-1:0] pul;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input bit e, input bit [N-1:0] r,
                     input bit [N-1:0] l, input bit [N-1:0] p);
    vec_t v;
    v.ena = e; v.raw = r; v.lvl = l; v.pul = p;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    rst_n   = 1'b0;
    ena     = 1'b1;
    btn_raw = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Table: clean press on ch1, then the rest join (ch1 must not re-pulse),
    // then release of all channels (no pulse on release).
    add(6, 1, 4'b0010, 4'b0000, 4'b0000);
    add(1, 1, 4'b0010, 4'b0010, 4'b0010);
    add(1, 1, 4'b0010, 4'b0010, 4'b0000);
    add(6, 1, 4'b1111, 4'b0010, 4'b0000);
    add(1, 1, 4'b1111, 4'b1111, 4'b1101);
    add(1, 1, 4'b1111, 4'b1111, 4'b0000);
    add(6, 1, 4'b0000, 4'b1111, 4'b0000);
    add(3, 1, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < vecs.size(); i++) begin
      ena     = vecs[i].ena;
      btn_raw = vecs[i].raw;
      tick();
      chk($sformatf("vec%0d_level", i), btn_level, vecs[i].lvl);
      chk($sformatf("vec%0d_pulse", i), btn_pulse, vecs[i].pul);
    end

    // Bounce on ch0: 1,0,1,0 each for 2 cycles, then low -> nothing accepted.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      btn_raw = (i < 8 && ((i / 2) % 2 == 0)) ? 4'b0001 : 4'b0000;
      tick();
      chk("bounce_level", btn_level, 4'b0000);
      chk("bounce_pulse", btn_pulse, 4'b0000);
    end
    // Held ch0 with a 3-cycle release glitch -> level stays high.
    btn_raw = 4'b0001;
    for (int i = 0; i < 8; i++) tick();
    chk("hold_level", btn_level, 4'b0001);
    btn_raw = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    btn_raw = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("release_glitch_level", btn_level, 4'b0001);
      chk("release_glitch_pulse", btn_pulse, 4'b0000);
    end

    // Simultaneous step on all channels.
    do_reset();
    btn_raw = 4'b1111;
    for (int i = 0; i < 6; i++) tick();
    chk("simul_pre_pulse", btn_pulse, 4'b0000);
    tick();
    chk("simul_pulse", btn_pulse, 4'b1111);
    chk("simul_level", btn_level, 4'b1111);
    tick();
    chk("simul_pulse_width", btn_pulse, 4'b0000);

    // ena dropped for 5 cycles mid-WAIT_HI on ch2.
    do_reset();
    btn_raw = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ena_off_pulse", btn_pulse, 4'b0000);
      chk("ena_off_level", btn_level, 4'b0000);
    end
    ena = 1'b1;
    tick(); chk("ena_resume1", btn_pulse, 4'b0000);
    tick(); chk("ena_resume2", btn_pulse, 4'b0000);
    tick(); chk("ena_resume_pulse", btn_pulse, 4'b0100);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_pulse[2]) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL ena_no_duplicate: got %0d extra pulses expected 0", pulses);
    end

    // Reset mid-WAIT_HI on ch3 with input held.
    do_reset();
    btn_raw = 4'b1000;
    for (int i = 0; i < 4; i++) tick();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_mid_wait_pulse", btn_pulse, 4'b0000);
    end
    tick();
    chk("rst_mid_fresh_pulse", btn_pulse, 4'b1000);
    tick();
    chk("rst_mid_single", btn_pulse, 4'b0000);
    chk("rst_mid_level", btn_level, 4'b1000);

    // Two coin presses as close as debounce allows (12 cycles apart > lockout).
    do_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      btn_raw = (i < 7 || i >= 12) ? 4'b0001 : 4'b0000;
      tick();
      if (btn_pulse[0]) pulses++;
    end
    n_checks++;
    if (pulses != 2) begin
      n_errors++;
      $display("FAIL coin_two_presses: got %0d pulses expected 2", pulses);
    end
    chk("coin_two_level", btn_level, 4'b0001);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(7) == 0) btn_raw[b] = ~btn_raw[b];
        ena = ($urandom_range(9) != 0);
        tick();
        chk("rand_level", btn_level, m_level);
        chk("rand_pulse", btn_pulse, model_pulse());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
